trng_vn_packer: RTL

- Upstream feeder for the 64-bit TRNG output FIFO.
- Takes the raw sampled bitstream from the ring-oscillator sampler and applies optional von Neumann debiasing.
- Packs the surviving bits LSB-first into 64-bit words and pushes each word into the FIFO through its wr_en/din/full interface.
- Also keeps status counters for delivered and dropped words.

---
 rtl/trng_vn_packer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/trng_vn_packer.sv
// Raw TRNG bitstream conditioner: optional von Neumann debias, LSB-first packing
// into 64-bit words, and a single-word output buffer feeding the FIFO write port.
module trng_vn_packer #(
    parameter int DROP_W     = 16,
    parameter int WORD_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  vn_bypass,
    input  logic                  raw_bit,
    input  logic                  raw_valid,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [63:0]           fifo_din,
    output logic [WORD_CNT_W-1:0] words_out,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  vn_valid
);

    logic                  r_pair_half;
    logic                  r_pair_bit;
    logic                  r_vn_valid;
    logic                  r_vn_bit;
    logic [6:0]            r_bit_cnt;
    logic [63:0]           r_shreg;
    logic [63:0]           r_out_reg;
    logic                  r_out_pending;
    logic [WORD_CNT_W-1:0] r_words_out;
    logic [DROP_W-1:0]     r_drop_cnt;

    logic                  w_wr_en;
    logic                  w_complete;
    logic                  w_load;
    logic                  w_drop;
    logic [63:0]           w_word;

    // Stage A: bypass holds pair_half at 0, which also covers the "bypass toggled"
    // case; enable=0 throws away any half pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_half <= 1'b0;
            r_pair_bit  <= 1'b0;
            r_vn_valid  <= 1'b0;
            r_vn_bit    <= 1'b0;
        end else begin
            r_vn_valid <= 1'b0;
            if (!enable) begin
                r_pair_half <= 1'b0;
            end else if (vn_bypass) begin
                r_pair_half <= 1'b0;
                if (raw_valid) begin
                    r_vn_valid <= 1'b1;
                    r_vn_bit   <= raw_bit;
                end
            end else if (raw_valid) begin
                if (!r_pair_half) begin
                    r_pair_bit  <= raw_bit;
                    r_pair_half <= 1'b1;
                end else begin
                    r_pair_half <= 1'b0;
                    if (raw_bit != r_pair_bit) begin
                        r_vn_valid <= 1'b1;
                        r_vn_bit   <= r_pair_bit;
                    end
                end
            end
        end
    end

    // FIFO port: a word is offered while out_pending; it transfers in any cycle
    // where fifo_wr_en (= out_pending && !fifo_full) is high.
    assign w_wr_en    = r_out_pending && !fifo_full;
    assign w_complete = r_vn_valid && (r_bit_cnt == 7'd63);
    assign w_load     = w_complete && (!r_out_pending || w_wr_en);
    assign w_drop     = w_complete && !w_load;
    assign w_word     = {r_vn_bit, r_shreg[62:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 7'd0;
            r_shreg   <= 64'd0;
        end else if (r_vn_valid) begin
            if (r_bit_cnt == 7'd63) begin
                r_bit_cnt <= 7'd0;
            end else begin
                r_shreg[r_bit_cnt[5:0]] <= r_vn_bit;
                r_bit_cnt               <= r_bit_cnt + 7'd1;
            end
        end
    end

    // A load in the same cycle as a drain keeps the buffer occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_reg     <= 64'd0;
            r_out_pending <= 1'b0;
        end else if (w_load) begin
            r_out_reg     <= w_word;
            r_out_pending <= 1'b1;
        end else if (w_wr_en) begin
            r_out_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words_out <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_wr_en) begin
                r_words_out <= r_words_out + WORD_CNT_W'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign fifo_wr_en = w_wr_en;
    assign fifo_din   = r_out_reg;
    assign words_out  = r_words_out;
    assign drop_cnt   = r_drop_cnt;
    assign vn_valid   = r_vn_valid;

endmodule
